// File: rtl/jtgng_objdraw_flex.sv
`default_nettype none
// ============================================================================
// Module  : jtgng_objdraw_flex
// Purpose : Draws one sprite row into an object line buffer. Pixels are
//           fetched four at a time from ROM and written one per cen cycle.
// Revision: 1.0 - initial release
// ============================================================================
module jtgng_objdraw_flex #(
  parameter int         CW     = 11,
  parameter int         PALW   = 4,
  parameter int         SPRH   = 16,
  parameter logic [3:0] TRANSP = 4'hf,
  parameter bit         FLIPEN = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cen,
  input  logic                         start,
  output logic                         busy,
  input  logic [CW-1:0]                code,
  input  logic [PALW-1:0]              pal,
  input  logic [8:0]                   xpos,
  input  logic [7:0]                   ypos,
  input  logic                         hflip,
  input  logic                         vflip,
  input  logic [7:0]                   vrender,
  output logic [CW+$clog2(SPRH)+1:0]   rom_addr,
  output logic                         rom_cs,
  input  logic                         rom_ok,
  input  logic [15:0]                  rom_data,
  output logic                         buf_we,
  output logic [8:0]                   buf_addr,
  output logic [PALW+3:0]              buf_data
);

  localparam int RW = $clog2(SPRH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAW  = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_code;
  logic [PALW-1:0] r_pal;
  logic [8:0]      r_xpos;
  logic [7:0]      r_ypos;
  logic            r_hflip;
  logic            r_vflip;
  logic [RW-1:0]   r_row;
  logic [1:0]      r_col;
  logic [1:0]      r_pix;
  logic [3:0]      r_z;
  logic [3:0]      r_y;
  logic [3:0]      r_x;
  logic [3:0]      r_w;

  logic [7:0]      w_dy;
  logic [1:0]      w_c;
  logic [3:0]      w_colour;
  logic [8:0]      w_col_addr;

  assign w_dy       = vrender - r_ypos;
  assign w_c        = r_hflip ? ~r_col : r_col;
  // Flipped rows are drawn from bit 0 upwards, otherwise from bit 3 down.
  assign w_colour   = r_hflip ? {r_w[0], r_x[0], r_y[0], r_z[0]}
                              : {r_w[3], r_x[3], r_y[3], r_z[3]};
  assign w_col_addr = r_xpos + {5'd0, r_col, r_pix};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      busy     <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      buf_we   <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      r_code   <= '0;
      r_pal    <= '0;
      r_xpos   <= '0;
      r_ypos   <= '0;
      r_hflip  <= 1'b0;
      r_vflip  <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_pix    <= '0;
      r_z      <= '0;
      r_y      <= '0;
      r_x      <= '0;
      r_w      <= '0;
    end else if (cen) begin
      buf_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_code  <= code;
            r_pal   <= pal;
            r_xpos  <= xpos;
            r_ypos  <= ypos;
            r_hflip <= hflip & FLIPEN;
            r_vflip <= vflip & FLIPEN;
            busy    <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          // The subtraction wraps, so sprites straddling line 255 still hit.
          if (w_dy >= 8'(SPRH)) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_row   <= r_vflip ? ~w_dy[RW-1:0] : w_dy[RW-1:0];
            r_col   <= 2'd0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          rom_cs   <= 1'b1;
          rom_addr <= {r_code, r_row, w_c};
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (rom_ok) begin
            {r_z, r_y, r_x, r_w} <= rom_data;
            rom_cs  <= 1'b0;
            r_pix   <= 2'd0;
            r_state <= S_DRAW;
          end
        end
        S_DRAW: begin
          buf_we   <= (w_colour != TRANSP);
          buf_addr <= w_col_addr;
          buf_data <= {r_pal, w_colour};
          if (r_hflip) begin
            r_z <= {1'b0, r_z[3:1]};
            r_y <= {1'b0, r_y[3:1]};
            r_x <= {1'b0, r_x[3:1]};
            r_w <= {1'b0, r_w[3:1]};
          end else begin
            r_z <= {r_z[2:0], 1'b0};
            r_y <= {r_y[2:0], 1'b0};
            r_x <= {r_x[2:0], 1'b0};
            r_w <= {r_w[2:0], 1'b0};
          end
          r_pix <= r_pix + 2'd1;
          if (r_pix == 2'd3) begin
            if (r_col != 2'd3) begin
              r_col   <= r_col + 2'd1;
              r_state <= S_REQ;
            end else begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          rom_cs  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/jtgng_objdraw_flex.md
Name: jtgng_objdraw_flex

Overview:
Parametrised sprite line drawer, successor to the fixed 1943-style object drawer. It takes one sprite's attributes through a start/busy handshake and checks vertical hit against the line being rendered. It then fetches the sprite row from ROM/SDRAM through a cs/ok handshake, with optional H/V flip, and writes non-transparent pixels into an external line buffer. It sits between the per-line sprite scanner and the object line buffer.

Parameters:
CW, 11, sprite code width
PALW, 4, palette bits per sprite
SPRH, 16, sprite height in lines (16 or 32)
TRANSP, 4'hf, colour index treated as transparent
FLIPEN, 1, 0 forces hflip/vflip inputs to be ignored

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cen  in  1  pixel clock enable; all state advances only when cen=1
start  in  1  attribute strobe, accepted only when busy=0
busy  out  1  sprite in progress
code  in  CW  sprite code
pal  in  PALW  palette
xpos  in  9  left pixel column
ypos  in  8  top line
hflip  in  1  horizontal flip
vflip  in  1  vertical flip
vrender  in  8  line being drawn
rom_addr  out  CW+log2(SPRH)+2  word address {code,row,col}
rom_cs  out  1  fetch request
rom_ok  in  1  data valid
rom_data  in  16  four 4bpp pixels, planes nibble-packed {z,y,x,w}
buf_we  out  1  line-buffer write
buf_addr  out  9  line-buffer column
buf_data  out  PALW+4  {pal,colour}

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, rom_cs=0, buf_we=0, rom_addr=0, buf_addr=0, buf_data=0. Reset mid-sprite aborts with no further writes.
- All state changes occur on posedge clk with cen=1. Outputs hold when cen=0.
- IDLE: start=1 latches all attributes and sets busy=1 the same edge, then goes to CHECK. start while busy=1 is ignored.
- CHECK: dy=(vrender-ypos) mod 256. If dy>=SPRH, go to IDLE (busy high exactly one cen cycle, no ROM access). Otherwise row=dy[log2(SPRH)-1:0], inverted if vflip&FLIPEN. col=0. Go to REQ.
- REQ: rom_cs=1, rom_addr={code,row,c}, where c=col or ~col if hflip&FLIPEN. Go to WAIT.
- WAIT: rom_cs held at 1 and address stable until a cen cycle with rom_ok=1. That cycle latches rom_data into shifters z,y,x,w, drops rom_cs, and goes to DRAW with pix=0. rom_ok while rom_cs=0 is ignored.
- DRAW: 4 cen cycles per word.
  - No flip: colour={w[3],x[3],y[3],z[3]}, registers shift left.
  - hflip: colour={w[0],x[0],y[0],z[0]}, registers shift right.
  - Each cycle: buf_addr=xpos+16*... no; buf_addr=xpos+4*col+pix (9-bit wrap), buf_data={pal,colour}, buf_we=(colour!=TRANSP).
  - After pix=3: if col<3, col++ and go to REQ; else go to IDLE with busy=0.
- buf_we is a single-cycle pulse per pixel, registered: it appears the cen cycle after the shift cycle and is 0 in every non-DRAW output cycle.
- Total cen cycles for an in-zone sprite with zero ROM wait: 1 CHECK + 4×(REQ+WAIT+4 DRAW) = 25. Each ROM wait cycle adds 1.
- x wrap: a column exceeding 511 wraps to 0. No clipping is done here.
- New start is accepted on the same edge busy falls? No. It is accepted only from IDLE, one cycle after busy=0.

Test Plan:
- Reset: rst_n low mid-WAIT -> rom_cs=0, busy=0, buf_we=0 immediately. After release, no write occurs until the next start.
- Miss: ypos=100, vrender=116, SPRH=16 -> busy for 1 cen cycle, rom_cs never asserted, no buf_we.
- Normal draw: code=5, ypos=10, vrender=13, xpos=20, rom_ok immediate, each word 16'h0F0F -> addresses {5,3,0..3}. Writes go to columns 20..35 only where colour!=4'hf. Busy lasts 25 cen cycles.
- Flip: same stimulus with hflip=vflip=1 -> row=12, column order 3,2,1,0. Pixel order within each word is reversed, checked against a bit-level model.
- Wrap and transparency: xpos=508, all-zero ROM data -> 16 writes to columns 508..511,0..11. With ROM=16'hFFFF and TRANSP=4'hf -> zero writes.
- Handshake: rom_ok delayed 3 cycles per word, and start pulsed during busy -> address held stable, total 37 cycles, the second start is ignored.
